// File: rtl/irq_ctl_if.sv
// CPU-side bus of the interrupt controller: I/O register access plus the
// interrupt request/vector/acknowledge handshake.
interface irq_ctl_if;
    logic        port_clk;
    logic [15:0] port;
    logic [7:0]  port_o;
    logic        port_w;
    logic [7:0]  port_i;
    logic        intr;
    logic [7:0]  irq;
    logic        intr_latch;

    modport master (
        output port_clk, port, port_o, port_w, intr_latch,
        input  port_i, intr, irq
    );

    modport slave (
        input  port_clk, port, port_o, port_w, intr_latch,
        output port_i, intr, irq
    );
endinterface

// File: rtl/irq_ctl.sv
// Edge-triggered interrupt controller: pending/mask/in-service registers,
// lowest-index-first priority, toggle-encoded acknowledge and EOI command.
module irq_ctl #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [7:0]  VEC_BASE  = 8'h08,
    parameter logic [15:0] PORT_BASE = 16'h0020,
    parameter bit          AUTO_EOI  = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_line,
    irq_ctl_if.slave           cpu
);

    localparam logic [15:0] ADDR_CMD  = PORT_BASE;
    localparam logic [15:0] ADDR_MASK = PORT_BASE + 16'd1;
    localparam logic [15:0] ADDR_ISR  = PORT_BASE + 16'd2;
    localparam logic [7:0]  CMD_EOI   = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t state, state_next;

    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] pending, pending_next;
    logic [NUM_IRQ-1:0] mask, mask_next;
    logic [NUM_IRQ-1:0] isr, isr_next;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] avail;
    logic [NUM_IRQ-1:0] sel_onehot;
    logic               copy;
    logic               ack;
    logic               eoi;
    logic               wr_mask;
    logic               clear_sel;
    logic               intr_q, intr_next;
    logic [7:0]         irq_q, irq_next;
    logic [2:0]         sel, sel_next;
    logic [2:0]         pick;
    logic               pick_valid;
    logic [7:0]         rd_data;

    assign rise    = irq_line & ~prev;
    assign ack     = cpu.intr_latch != copy;
    assign eoi     = cpu.port_clk & cpu.port_w & (cpu.port == ADDR_CMD) & (cpu.port_o == CMD_EOI);
    assign wr_mask = cpu.port_clk & cpu.port_w & (cpu.port == ADDR_MASK);
    assign avail   = pending & ~mask;

    // Scanning downwards leaves the lowest unmasked pending channel selected.
    always_comb begin
        pick       = 3'd0;
        pick_valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (avail[i]) begin
                pick       = 3'(i);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            sel_onehot[i] = (sel == 3'(i));
        end
    end

    always_comb begin
        state_next = state;
        intr_next  = intr_q;
        irq_next   = irq_q;
        sel_next   = sel;
        isr_next   = isr;
        clear_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    sel_next   = pick;
                    irq_next   = VEC_BASE + {5'd0, pick};
                    intr_next  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // Vector and request stay frozen here until the CPU acknowledges.
                if (ack) begin
                    clear_sel = 1'b1;
                    intr_next = 1'b0;
                    if (AUTO_EOI) begin
                        state_next = IDLE;
                    end else begin
                        isr_next   = isr | sel_onehot;
                        state_next = SERVICE;
                    end
                end
            end
            SERVICE: begin
                if (eoi) begin
                    isr_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A fresh edge in the acknowledge cycle re-arms the channel: set wins over clear.
    assign pending_next = (pending & ~({NUM_IRQ{clear_sel}} & sel_onehot)) | rise;
    assign mask_next    = wr_mask ? cpu.port_o[NUM_IRQ-1:0] : mask;

    // Edge and acknowledge detectors resync to the live inputs in reset so
    // that a line held high through reset does not look like a new edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            mask    <= '0;
            isr     <= '0;
            intr_q  <= 1'b0;
            irq_q   <= 8'h00;
            sel     <= 3'd0;
            prev    <= irq_line;
            copy    <= cpu.intr_latch;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            mask    <= mask_next;
            isr     <= isr_next;
            intr_q  <= intr_next;
            irq_q   <= irq_next;
            sel     <= sel_next;
            prev    <= irq_line;
            copy    <= cpu.intr_latch;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (cpu.port)
            ADDR_CMD:  rd_data[NUM_IRQ-1:0] = pending;
            ADDR_MASK: rd_data[NUM_IRQ-1:0] = mask;
            ADDR_ISR:  rd_data[NUM_IRQ-1:0] = isr;
            default:   rd_data = 8'h00;
        endcase
    end

    assign cpu.port_i = rd_data;
    assign cpu.intr   = intr_q;
    assign cpu.irq    = irq_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: a default instance and an AUTO_EOI instance share one
// stimulus stream and are checked every cycle against a channel-level model.
module tb_irq_ctl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  line  = 8'h00;
    logic        pclk  = 1'b0;
    logic [15:0] paddr = 16'h0000;
    logic [7:0]  pdata = 8'h00;
    logic        pw    = 1'b0;
    logic        latch = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    irq_ctl_if bus_a ();
    irq_ctl_if bus_b ();

    assign bus_a.port_clk   = pclk;
    assign bus_a.port       = paddr;
    assign bus_a.port_o     = pdata;
    assign bus_a.port_w     = pw;
    assign bus_a.intr_latch = latch;
    assign bus_b.port_clk   = pclk;
    assign bus_b.port       = paddr;
    assign bus_b.port_o     = pdata;
    assign bus_b.port_w     = pw;
    assign bus_b.intr_latch = latch;

    irq_ctl #(.NUM_IRQ(8), .VEC_BASE(8'h08), .PORT_BASE(16'h0020), .AUTO_EOI(1'b0)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .irq_line (line),
        .cpu      (bus_a)
    );

    irq_ctl #(.NUM_IRQ(8), .VEC_BASE(8'h08), .PORT_BASE(16'h0020), .AUTO_EOI(1'b1)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .irq_line (line),
        .cpu      (bus_b)
    );

    always #5 clock = ~clock;

    // Model state per instance: channel awaiting acknowledge and channel in
    // service are held as channel numbers, -1 meaning none.
    int         m_req  [2];
    int         m_srv  [2];
    logic [7:0] m_pend [2];
    logic [7:0] m_mask [2];
    logic [7:0] m_irq  [2];
    logic [7:0] m_prev [2];
    logic       m_copy [2];

    task automatic model_step(input int k, input bit auto_eoi);
        logic [7:0] rises;
        logic [7:0] ready;
        int         req_was;
        int         srv_was;
        int         chosen;
        bit         acked;
        bit         eoi_cmd;
        if (reset) begin
            m_req[k]  = -1;
            m_srv[k]  = -1;
            m_pend[k] = 8'h00;
            m_mask[k] = 8'h00;
            m_irq[k]  = 8'h00;
            m_prev[k] = line;
            m_copy[k] = latch;
            return;
        end
        acked   = (latch != m_copy[k]);
        rises   = line & ~m_prev[k];
        eoi_cmd = pclk && pw && (paddr == 16'h0020) && (pdata == 8'h20);
        req_was = m_req[k];
        srv_was = m_srv[k];
        ready   = m_pend[k] & ~m_mask[k];
        if (req_was >= 0) begin
            if (acked) begin
                m_pend[k][req_was] = 1'b0;
                m_req[k] = -1;
                if (!auto_eoi) m_srv[k] = req_was;
            end
        end else if (srv_was >= 0) begin
            if (eoi_cmd) m_srv[k] = -1;
        end else if (ready != 8'h00) begin
            chosen = 0;
            while (!ready[chosen]) chosen++;
            m_req[k] = chosen;
            m_irq[k] = 8'h08 + 8'(chosen);
        end
        m_pend[k] = m_pend[k] | rises;
        if (pclk && pw && paddr == 16'h0021) m_mask[k] = pdata;
        m_prev[k] = line;
        m_copy[k] = latch;
    endtask

    function automatic logic [7:0] model_read(input int k);
        case (paddr)
            16'h0020: return m_pend[k];
            16'h0021: return m_mask[k];
            16'h0022: return (m_srv[k] >= 0) ? (8'h01 << m_srv[k]) : 8'h00;
            default:  return 8'h00;
        endcase
    endfunction

    task automatic check_value(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_output();
        check_value("a_intr", {7'd0, bus_a.intr}, {7'd0, m_req[0] >= 0});
        check_value("a_irq", bus_a.irq, m_irq[0]);
        check_value("a_port_i", bus_a.port_i, model_read(0));
        check_value("b_intr", {7'd0, bus_b.intr}, {7'd0, m_req[1] >= 0});
        check_value("b_irq", bus_b.irq, m_irq[1]);
        check_value("b_port_i", bus_b.port_i, model_read(1));
    endtask

    task automatic apply_stimulus();
        @(posedge clock);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        check_output();
    endtask

    task automatic do_ack();
        latch = ~latch;
        apply_stimulus();
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        pclk  = 1'b1;
        pw    = 1'b1;
        paddr = addr;
        pdata = data;
        apply_stimulus();
        pclk  = 1'b0;
        pw    = 1'b0;
    endtask

    task automatic expect_read(input string tag, input int k, input logic [15:0] addr, input logic [7:0] expected);
        paddr = addr;
        #1;
        check_value(tag, (k == 0) ? bus_a.port_i : bus_b.port_i, expected);
    endtask

    task automatic drain();
        repeat (3) begin
            do_ack();
            do_write(16'h0020, 8'h20);
            apply_stimulus();
        end
    endtask

    initial begin
        int sel;
        $display("[TB] start");
        reset = 1'b1;
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        apply_stimulus();
        check_value("reset_intr", {7'd0, bus_a.intr}, 8'h00);
        check_value("reset_irq", bus_a.irq, 8'h00);
        expect_read("reset_pend", 0, 16'h0020, 8'h00);

        // Line 2 delivered two edges after its rise, then ack and EOI.
        line = 8'h04;
        apply_stimulus();
        check_value("l2_not_yet", {7'd0, bus_a.intr}, 8'h00);
        apply_stimulus();
        check_value("l2_intr", {7'd0, bus_a.intr}, 8'h01);
        check_value("l2_vec", bus_a.irq, 8'h0A);
        do_ack();
        check_value("l2_ack_intr", {7'd0, bus_a.intr}, 8'h00);
        expect_read("l2_isr", 0, 16'h0022, 8'h04);
        do_write(16'h0020, 8'h20);
        expect_read("l2_isr_eoi", 0, 16'h0022, 8'h00);

        // Lines 5 and 1 together: channel 1 first, then 5 after EOI.
        line = 8'h00;
        apply_stimulus();
        line = 8'h22;
        apply_stimulus();
        apply_stimulus();
        check_value("pri_vec1", bus_a.irq, 8'h09);
        do_ack();
        do_write(16'h0020, 8'h20);
        apply_stimulus();
        check_value("pri_intr5", {7'd0, bus_a.intr}, 8'h01);
        check_value("pri_vec5", bus_a.irq, 8'h0D);
        drain();

        // Masked edge still pends; unmasking delivers it.
        do_write(16'h0021, 8'hFF);
        line = 8'h00;
        apply_stimulus();
        line = 8'h08;
        apply_stimulus();
        apply_stimulus();
        check_value("mask_no_intr", {7'd0, bus_a.intr}, 8'h00);
        expect_read("mask_pend", 0, 16'h0020, 8'h08);
        do_write(16'h0021, 8'h00);
        apply_stimulus();
        check_value("unmask_intr", {7'd0, bus_a.intr}, 8'h01);
        check_value("unmask_vec", bus_a.irq, 8'h0B);
        drain();

        // AUTO_EOI instance: no in-service bit, next edge delivered without EOI.
        line = 8'h00;
        apply_stimulus();
        line = 8'h01;
        apply_stimulus();
        apply_stimulus();
        do_ack();
        check_value("auto_ack_intr", {7'd0, bus_b.intr}, 8'h00);
        expect_read("auto_isr", 1, 16'h0022, 8'h00);
        line = 8'h00;
        apply_stimulus();
        line = 8'h01;
        apply_stimulus();
        apply_stimulus();
        check_value("auto_again_intr", {7'd0, bus_b.intr}, 8'h01);
        check_value("auto_again_vec", bus_b.irq, 8'h08);
        drain();

        // Line 4 re-edges in its own acknowledge cycle.
        line = 8'h00;
        apply_stimulus();
        line = 8'h10;
        apply_stimulus();
        apply_stimulus();
        check_value("reedge_vec", bus_a.irq, 8'h0C);
        line = 8'h00;
        apply_stimulus();
        line = 8'h10;
        do_ack();
        paddr = 16'h0020;
        #1;
        check_value("reedge_pend4", bus_a.port_i & 8'h10, 8'h10);
        drain();

        // Reset in SERVICE with line 6 held high abandons everything.
        line = 8'h00;
        apply_stimulus();
        line = 8'h40;
        apply_stimulus();
        apply_stimulus();
        do_ack();
        expect_read("srv_isr6", 0, 16'h0022, 8'h40);
        reset = 1'b1;
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        repeat (3) begin
            apply_stimulus();
            check_value("post_reset_intr", {7'd0, bus_a.intr}, 8'h00);
        end
        check_value("post_reset_irq", bus_a.irq, 8'h00);
        expect_read("post_reset_pend", 0, 16'h0020, 8'h00);
        expect_read("post_reset_mask", 0, 16'h0021, 8'h00);
        expect_read("post_reset_isr", 0, 16'h0022, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            line  = line ^ 8'($urandom & $urandom & $urandom);
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) latch = ~latch;
            sel = $urandom_range(0, 9);
            pclk  = 1'b0;
            pw    = 1'b0;
            paddr = 16'h001E + 16'($urandom_range(0, 5));
            pdata = 8'($urandom);
            if (sel == 0) begin
                pclk  = 1'b1;
                pw    = 1'b1;
                paddr = 16'h0020;
                pdata = 8'h20;
            end else if (sel == 1) begin
                pclk  = 1'b1;
                pw    = 1'b1;
                paddr = 16'h0021;
                pdata = 8'($urandom & $urandom);
            end else if (sel == 2) begin
                pclk  = 1'b1;
                pw    = 1'b1;
                paddr = 16'h0020;
            end else if (sel == 3) begin
                pclk  = 1'b1;
            end
            apply_stimulus();
        end
        reset = 1'b0;
        pclk  = 1'b0;
        pw    = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request channels (legal 1..8).
REQ-002 SHALL have parameter VEC_BASE, default 8'h08, vector issued for channel 0.
REQ-003 SHALL have parameter PORT_BASE, default 16'h0020, base I/O address of the register block.
REQ-004 SHALL have parameter AUTO_EOI, default 0, 1 = in-service cleared on acknowledge.
REQ-005 SHALL have port clock  in  1  the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port irq_line  in  NUM_IRQ  raw device requests, rising-edge triggered.
REQ-008 SHALL have port port_clk  in  1  one-cycle I/O access strobe from the CPU.
REQ-009 SHALL have port port  in  16  I/O address.
REQ-010 SHALL have port port_o  in  8  CPU write data.
REQ-011 SHALL have port port_w  in  1  write qualifier, sampled with port_clk.
REQ-012 SHALL have port port_i  out  8  read data, combinational from port.
REQ-013 SHALL have port intr  out  1  interrupt request to CPU, registered.
REQ-014 SHALL have port irq  out  8  interrupt vector, registered, valid while intr=1.
REQ-015 SHALL have port intr_latch  in  1  CPU acknowledge, toggle-encoded.

Function
REQ-016 SHALL register irq_line into prev each cycle; a channel whose irq_line=1 and prev=0 SHALL set its pending bit on that edge.
REQ-017 SHALL keep a latch copy register; acknowledge = (intr_latch != copy); copy SHALL take intr_latch every cycle.
REQ-018 SHALL implement states IDLE, REQ, SERVICE.
REQ-019 IDLE: if (pending & ~mask) nonzero, SHALL select lowest-index such channel, set irq = VEC_BASE + index (8-bit wrap), intr=1, go REQ next edge.
REQ-020 REQ: intr and irq SHALL stay frozen until acknowledge, even if mask or pending change.
REQ-021 REQ on acknowledge: SHALL clear selected pending bit, drop intr; AUTO_EOI=0 -> set selected isr bit, go SERVICE; AUTO_EOI=1 -> go IDLE, isr unchanged.
REQ-022 SERVICE: no new intr; on EOI SHALL clear isr and go IDLE.
REQ-023 Acknowledge in IDLE or SERVICE SHALL be ignored (copy still resynchronised).
REQ-024 New edge on the selected channel in the acknowledge cycle SHALL leave its pending bit set (set wins over clear).
REQ-025 Write (port_clk & port_w) PORT_BASE with port_o=8'h20 SHALL be EOI; other values at PORT_BASE ignored.
REQ-026 Write PORT_BASE+1 SHALL load mask from port_o[NUM_IRQ-1:0].
REQ-027 Read PORT_BASE -> pending, PORT_BASE+1 -> mask, PORT_BASE+2 -> isr; bits >= NUM_IRQ read 0; other addresses read 8'h00.
REQ-028 Masked edges SHALL still set pending; unmasking SHALL allow delivery next IDLE cycle.
REQ-029 Latency: irq_line rising before edge k -> pending at k -> intr=1 after edge k+1.

Reset
REQ-030 On reset SHALL set state IDLE, pending=0, mask=0, isr=0, intr=0, irq=8'h00, prev=irq_line, copy=intr_latch.
REQ-031 Reset mid-REQ or mid-SERVICE SHALL abandon the interrupt; no acknowledge or EOI required afterwards.
REQ-032 An irq_line held high through reset SHALL NOT create a pending bit after reset release.

Verification
REQ-033 Line 2 rises, defaults -> intr=1 two edges later, irq=8'h0A; toggle intr_latch -> intr=0, isr=8'h04; write 8'h20 to 16'h0020 -> isr=0.
REQ-034 Lines 5 and 1 rise same cycle -> irq=8'h09 first; after ack+EOI -> irq=8'h0D delivered.
REQ-035 Mask=8'hFF, line 3 rises -> no intr, read 16'h0020 = 8'h08; write mask 8'h00 -> intr=1, irq=8'h0B.
REQ-036 AUTO_EOI=1: line 0 rises, ack -> intr=0, isr stays 0, second line 0 edge delivered without EOI.
REQ-037 Line 4 re-edges in its ack cycle -> pending bit 4 remains 1 after ack.
REQ-038 Reset asserted in SERVICE with line 6 held high -> all registers 0, no intr after release.
